// File: rtl/i2s_rx.sv
// I2S / MSB-justified / LSB-justified serial audio receiver.
// All three serial inputs are synchronized into clk, and words are handed off with a valid/ready handshake.
module i2s_rx #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sck,
    input  logic        ws,
    input  logic        sd,
    input  logic        rx_en,
    input  logic [1:0]  word_size,
    input  logic        frame_size,
    input  logic [1:0]  standard,
    input  logic        stereo,
    input  logic        mute,
    input  logic        rx_ready,
    output logic [31:0] rx_data,
    output logic        rx_left,
    output logic        rx_valid,
    output logic        overrun,
    output logic        frame_err,
    output logic        cfg_err,
    output logic [1:0]  state
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_L    = 2'd1,
        ST_R    = 2'd2,
        ST_ERR  = 2'd3
    } state_e;

    typedef struct packed {
        logic [1:0] word_size;
        logic       frame_size;
        logic [1:0] standard;
        logic       stereo;
    } cfg_t;

    logic [2:0]  sync_q [SYNC_STAGES];
    logic        sck_prev_q;
    logic        ws_q;
    logic [5:0]  p_q, p_d;
    logic [30:0] sr_q, sr_d;
    cfg_t        cfg_q, cfg_live, cfg_eff;
    state_e      state_q, state_d;
    logic [31:0] data_q;
    logic        left_q, valid_q, overrun_q, frame_err_q, cfg_err_q;

    logic        sck_s, ws_s, sd_s, sck_edge, ws_chg, left_lvl, cfg_err_c, at_last;
    logic [6:0]  w_c, f_c, last_c, pos_c;
    logic        in_win, done, deliver;
    logic [31:0] word_c;

    function automatic logic [6:0] word_bits(input logic [1:0] code);
        case (code)
            2'b00:   return 7'd16;
            2'b01:   return 7'd24;
            default: return 7'd32;
        endcase
    endfunction

    // NOTE: the synchronizer array is reset element by element; a memory needs an explicit loop to get a reset value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            sck_prev_q <= 1'b0;
        end else begin
            sync_q[0] <= {sck, ws, sd};
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            sck_prev_q <= sck_s;
        end
    end

    assign {sck_s, ws_s, sd_s} = sync_q[SYNC_STAGES-1];
    assign sck_edge = sck_s & ~sck_prev_q;

    // NOTE: every signal driven here gets a value on every path first, so no latch is inferred.
    always_comb begin
        cfg_live  = '{word_size: word_size, frame_size: frame_size, standard: standard, stereo: stereo};
        cfg_eff   = (state_q == ST_IDLE) ? cfg_live : cfg_q;
        w_c       = word_bits(cfg_eff.word_size);
        f_c       = cfg_eff.frame_size ? 7'd32 : 7'd16;
        last_c    = f_c - 7'd1;
        cfg_err_c = rx_en && (word_size == 2'b11 || standard == 2'b11 ||
                              word_bits(word_size) > (frame_size ? 7'd32 : 7'd16));
        left_lvl  = (cfg_eff.standard != 2'b00);
        ws_chg    = ws_s ^ ws_q;
        at_last   = ({1'b0, p_q} == last_c);

        p_d = p_q;
        if (sck_edge) p_d = ws_chg ? 6'd0 : ((p_q == 6'd63) ? p_q : p_q + 6'd1);

        // I2S data lags WS by one SCK, so its bit at a WS change still belongs to the old slot.
        pos_c = (cfg_eff.standard == 2'b00) ? ({1'b0, p_q} + 7'd1) : {1'b0, p_d};
        case (cfg_eff.standard)
            2'b00: begin
                in_win = (pos_c >= 7'd1) && (pos_c <= w_c);
                done   = (pos_c == w_c);
            end
            2'b01: begin
                in_win = (pos_c < w_c);
                done   = (pos_c == w_c - 7'd1);
            end
            default: begin
                in_win = (pos_c >= f_c - w_c) && (pos_c <= last_c);
                done   = (pos_c == last_c);
            end
        endcase

        sr_d = sr_q;
        if (sck_edge && in_win) sr_d = {sr_q[29:0], sd_s};
        word_c = {sr_q, sd_s} & (32'hFFFF_FFFF >> (7'd32 - w_c));
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (!rx_en) begin
            state_d = ST_IDLE;
        end else if (sck_edge) begin
            unique case (state_q)
                ST_IDLE: if (ws_chg && ws_s == left_lvl && !cfg_err_c) state_d = ST_L;
                ST_L:    if (ws_chg != at_last) state_d = ST_ERR; else if (ws_chg) state_d = ST_R;
                ST_R:    if (ws_chg != at_last) state_d = ST_ERR; else if (ws_chg) state_d = ST_L;
                ST_ERR:  if (ws_chg && ws_s == left_lvl) state_d = ST_L;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        deliver = sck_edge && done &&
                  (state_q == ST_L || (state_q == ST_R && cfg_q.stereo)) &&
                  (state_d == ST_L || state_d == ST_R);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ws_q  <= 1'b0;
            p_q   <= '0;
            sr_q  <= '0;
            cfg_q <= '0;
        end else begin
            if (sck_edge) ws_q <= ws_s;
            p_q  <= p_d;
            sr_q <= sr_d;
            if (state_q == ST_IDLE && state_d == ST_L) cfg_q <= cfg_live;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q      <= '0;
            left_q      <= 1'b0;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else begin
            cfg_err_q <= cfg_err_c;
            if (deliver) begin
                data_q  <= mute ? '0 : word_c;
                left_q  <= (state_q == ST_L);
                valid_q <= 1'b1;
                if (valid_q && !rx_ready) overrun_q <= 1'b1;
            end else if (valid_q && rx_ready) begin
                valid_q <= 1'b0;
            end
            if (state_d == ST_ERR && state_q != ST_ERR) frame_err_q <= 1'b1;
            if (!rx_en) begin
                overrun_q   <= 1'b0;
                frame_err_q <= 1'b0;
            end
        end
    end

    assign rx_data   = data_q;
    assign rx_left   = left_q;
    assign rx_valid  = valid_q;
    assign overrun   = overrun_q;
    assign frame_err = frame_err_q;
    assign cfg_err   = cfg_err_q;
    assign state     = state_q;
endmodule

// File: tb/tb_i2s_rx.sv
// Self-checking bench for i2s_rx: a serial-frame generator pushes expected words into a scoreboard
// that a handshake monitor pops and compares.
module tb_i2s_rx;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        sck = 1'b0, ws = 1'b0, sd = 1'b0, rx_en = 1'b0;
    logic [1:0]  word_size = 2'b00, standard = 2'b00;
    logic        frame_size = 1'b0, stereo = 1'b1, mute = 1'b0, rx_ready = 1'b1;
    logic [31:0] rx_data;
    logic        rx_left, rx_valid, overrun, frame_err, cfg_err;
    logic [1:0]  state;

    typedef struct {
        logic [31:0] data;
        logic        left;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0, n_fail = 0, valid_cycles = 0;
    int   cur_f = 16, cur_w = 16, cur_std = 0;
    logic lvl_l = 1'b0, i2s_dly = 1'b0;

    i2s_rx #(.SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .sck(sck), .ws(ws), .sd(sd), .rx_en(rx_en),
        .word_size(word_size), .frame_size(frame_size), .standard(standard),
        .stereo(stereo), .mute(mute), .rx_ready(rx_ready),
        .rx_data(rx_data), .rx_left(rx_left), .rx_valid(rx_valid),
        .overrun(overrun), .frame_err(frame_err), .cfg_err(cfg_err), .state(state)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Pops the scoreboard on every accepted word.
    always @(negedge clk) begin
        if (rst_n && rx_valid) valid_cycles++;
        if (rst_n && rx_valid && rx_ready) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_word: got data=%h left=%b, expected none", rx_data, rx_left);
            end else begin
                mon_e = sb.pop_front();
                if (rx_data !== mon_e.data || rx_left !== mon_e.left) begin
                    n_fail++;
                    $display("FAIL word: got data=%h left=%b, expected data=%h left=%b",
                             rx_data, rx_left, mon_e.data, mon_e.left);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic w, input logic d);
        ws = w;
        if (cur_std == 0) begin
            sd = i2s_dly;
            i2s_dly = d;
        end else begin
            sd = d;
        end
        sck = 1'b0;
        tick(4);
        sck = 1'b1;
        tick(4);
    endtask

    task automatic send_slot(input logic lvl, input logic [31:0] word, input int nbits, input logic pad);
        logic       b;
        logic [4:0] idx;
        for (int p = 0; p < nbits; p++) begin
            if (cur_std == 2) begin
                idx = 5'(cur_f - 1 - p);
                b = (p >= cur_f - cur_w) ? word[idx] : pad;
            end else begin
                idx = 5'(cur_w - 1 - p);
                b = (p < cur_w) ? word[idx] : pad;
            end
            send_bit(lvl, b);
        end
    endtask

    task automatic set_cfg(input logic [1:0] wsz, input logic fs, input logic [1:0] std, input logic st);
        word_size  = wsz;
        frame_size = fs;
        standard   = std;
        stereo     = st;
        cur_w      = (wsz == 2'b00) ? 16 : (wsz == 2'b01) ? 24 : 32;
        cur_f      = fs ? 32 : 16;
        cur_std    = int'(std);
        lvl_l      = (std != 2'b00);
        i2s_dly    = 1'b0;
    endtask

    task automatic start_stream();
        rx_en = 1'b1;
        tick(2);
        for (int i = 0; i < 3; i++) send_bit(~lvl_l, 1'b0);
    endtask

    task automatic finish_stream(input string name);
        tick(8);
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL %s_pending: got %0d undelivered words, expected 0", name, sb.size());
        end
        sb.delete();
        rx_en = 1'b0;
        tick(4);
    endtask

    task automatic test_reset();
        rx_en = 1'b1;
        set_cfg(2'b10, 1'b0, 2'b00, 1'b1);
        tick(5);
        n_checks++;
        if ({rx_data, rx_left, rx_valid, overrun, frame_err, cfg_err, state} !== 39'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got data=%h l=%b v=%b ov=%b fe=%b ce=%b st=%0d, expected all 0",
                     rx_data, rx_left, rx_valid, overrun, frame_err, cfg_err, state);
        end
        rx_en = 1'b0;
        set_cfg(2'b00, 1'b0, 2'b00, 1'b1);
        rst_n = 1'b1;
        tick(4);
    endtask

    task automatic test_i2s_stereo();
        int v0;
        set_cfg(2'b00, 1'b0, 2'b00, 1'b1);
        rx_ready = 1'b1;
        start_stream();
        v0 = valid_cycles;
        sb.push_back('{32'h0000A5C3, 1'b1});
        sb.push_back('{32'h00000F0F, 1'b0});
        send_slot(1'b0, 32'hA5C3, 16, 1'b0);
        send_slot(1'b1, 32'h0F0F, 16, 1'b0);
        send_bit(1'b0, 1'b0);
        tick(8);
        n_checks++;
        if (valid_cycles - v0 != 2) begin
            n_fail++;
            $display("FAIL i2s_valid_cycles: got %0d, expected 2", valid_cycles - v0);
        end
        finish_stream("i2s");
    endtask

    task automatic test_lsb_mono();
        set_cfg(2'b01, 1'b1, 2'b10, 1'b0);
        start_stream();
        sb.push_back('{32'h00123456, 1'b1});
        send_slot(1'b1, 32'h00123456, 32, 1'b1);
        send_slot(1'b0, 32'h00ABCDEF, 32, 1'b1);
        send_bit(1'b1, 1'b1);
        finish_stream("lsb");
    endtask

    task automatic test_msb_mute();
        set_cfg(2'b00, 1'b1, 2'b01, 1'b1);
        start_stream();
        sb.push_back('{32'h00001234, 1'b1});
        sb.push_back('{32'h00008001, 1'b0});
        send_slot(1'b1, 32'h1234, 32, 1'b1);
        send_slot(1'b0, 32'h8001, 32, 1'b0);
        mute = 1'b1;
        sb.push_back('{32'h0, 1'b1});
        sb.push_back('{32'h0, 1'b0});
        send_slot(1'b1, 32'hFFFF, 32, 1'b0);
        send_slot(1'b0, 32'hAAAA, 32, 1'b1);
        send_bit(1'b1, 1'b0);
        tick(8);
        mute = 1'b0;
        finish_stream("msb");
    endtask

    task automatic test_overrun();
        set_cfg(2'b00, 1'b0, 2'b00, 1'b1);
        rx_ready = 1'b0;
        start_stream();
        send_slot(1'b0, 32'h1111, 16, 1'b0);
        send_slot(1'b1, 32'h2222, 16, 1'b0);
        send_bit(1'b0, 1'b0);
        tick(4);
        n_checks++;
        if (overrun !== 1'b1 || rx_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL overrun_flag: got ov=%b v=%b, expected ov=1 v=1", overrun, rx_valid);
        end
        n_checks++;
        if (rx_data !== 32'h00002222 || rx_left !== 1'b0) begin
            n_fail++;
            $display("FAIL overrun_data: got %h left=%b, expected 00002222 left=0", rx_data, rx_left);
        end
        sb.push_back('{32'h00002222, 1'b0});
        rx_ready = 1'b1;
        tick(3);
        n_checks++;
        if (rx_valid !== 1'b0 || overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL overrun_sticky: got v=%b ov=%b, expected v=0 ov=1", rx_valid, overrun);
        end
        finish_stream("overrun");
        n_checks++;
        if (overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL overrun_clear: got %b, expected 0", overrun);
        end
    endtask

    task automatic test_frame_err();
        int v0;
        set_cfg(2'b00, 1'b0, 2'b00, 1'b1);
        start_stream();
        v0 = valid_cycles;
        send_slot(1'b0, 32'h1234, 12, 1'b0);
        send_slot(1'b1, 32'h5678, 16, 1'b0);
        n_checks++;
        if (state !== 2'd3 || frame_err !== 1'b1) begin
            n_fail++;
            $display("FAIL err_entry: got state=%0d fe=%b, expected state=3 fe=1", state, frame_err);
        end
        n_checks++;
        if (valid_cycles != v0) begin
            n_fail++;
            $display("FAIL err_no_valid: got %0d valid cycles, expected 0", valid_cycles - v0);
        end
        sb.push_back('{32'h0000BEEF, 1'b1});
        send_slot(1'b0, 32'hBEEF, 16, 1'b0);
        n_checks++;
        if (state !== 2'd1) begin
            n_fail++;
            $display("FAIL err_recover: got state=%0d, expected 1", state);
        end
        send_bit(1'b1, 1'b0);
        tick(4);
        n_checks++;
        if (frame_err !== 1'b1) begin
            n_fail++;
            $display("FAIL frame_err_sticky: got %b, expected 1", frame_err);
        end
        finish_stream("frame_err");
        n_checks++;
        if (frame_err !== 1'b0) begin
            n_fail++;
            $display("FAIL frame_err_clear: got %b, expected 0", frame_err);
        end
    endtask

    task automatic test_cfg_err();
        int v0;
        set_cfg(2'b10, 1'b0, 2'b00, 1'b1);
        start_stream();
        v0 = valid_cycles;
        n_checks++;
        if (cfg_err !== 1'b1) begin
            n_fail++;
            $display("FAIL cfg_err_w_gt_f: got %b, expected 1", cfg_err);
        end
        for (int f = 0; f < 4; f++) begin
            send_slot(1'b0, $urandom, 16, 1'b0);
            send_slot(1'b1, $urandom, 16, 1'b0);
            n_checks++;
            if (state !== 2'd0 || cfg_err !== 1'b1) begin
                n_fail++;
                $display("FAIL cfg_err_idle: frame %0d got state=%0d ce=%b, expected state=0 ce=1",
                         f, state, cfg_err);
            end
        end
        n_checks++;
        if (valid_cycles != v0) begin
            n_fail++;
            $display("FAIL cfg_err_no_valid: got %0d valid cycles, expected 0", valid_cycles - v0);
        end
        word_size = 2'b11; frame_size = 1'b1;
        tick(3);
        n_checks++;
        if (cfg_err !== 1'b1) begin
            n_fail++;
            $display("FAIL cfg_err_ws11: got %b, expected 1", cfg_err);
        end
        word_size = 2'b00; standard = 2'b11;
        tick(3);
        n_checks++;
        if (cfg_err !== 1'b1) begin
            n_fail++;
            $display("FAIL cfg_err_std11: got %b, expected 1", cfg_err);
        end
        word_size = 2'b10; standard = 2'b01;
        tick(3);
        n_checks++;
        if (cfg_err !== 1'b0) begin
            n_fail++;
            $display("FAIL cfg_ok_32_32: got %b, expected 0", cfg_err);
        end
        finish_stream("cfg_err");
    endtask

    task automatic test_reset_midword();
        set_cfg(2'b00, 1'b0, 2'b00, 1'b1);
        rx_ready = 1'b0;
        start_stream();
        send_slot(1'b0, 32'h1357, 16, 1'b0);
        send_slot(1'b1, 32'h2468, 16, 1'b0);
        send_slot(1'b0, 32'h9999, 8, 1'b0);
        n_checks++;
        if (rx_valid !== 1'b1 || overrun !== 1'b1 || state !== 2'd1) begin
            n_fail++;
            $display("FAIL pre_reset: got v=%b ov=%b st=%0d, expected v=1 ov=1 st=1", rx_valid, overrun, state);
        end
        rst_n = 1'b0;
        tick(3);
        n_checks++;
        if ({rx_data, rx_left, rx_valid, overrun, frame_err, cfg_err, state} !== 39'd0) begin
            n_fail++;
            $display("FAIL midword_reset: got data=%h l=%b v=%b ov=%b fe=%b ce=%b st=%0d, expected all 0",
                     rx_data, rx_left, rx_valid, overrun, frame_err, cfg_err, state);
        end
        rx_ready = 1'b1;
        rst_n = 1'b1;
        tick(2);
        send_slot(1'b0, 32'h0099, 8, 1'b0);
        n_checks++;
        if (state !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_wait_idle: got state=%0d, expected 0", state);
        end
        send_slot(1'b1, 32'h0000, 16, 1'b0);
        sb.push_back('{32'h00005A5A, 1'b1});
        send_slot(1'b0, 32'h5A5A, 16, 1'b0);
        send_bit(1'b1, 1'b0);
        finish_stream("reset_midword");
    endtask

    initial begin
        test_reset();
        test_i2s_stereo();
        test_lsb_mono();
        test_msb_mute();
        test_overrun();
        test_frame_err();
        test_cfg_err();
        test_reset_midword();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/i2s_rx.md
I2S_RX -- requirements
Module: i2s_rx

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: the number of synchronizer flops on each of sck, ws and sd before edge detection.
REQ-002 SHALL have ports, in this order:
- clk  in  1  system clock; the only clock.
- rst_n  in  1  reset, asynchronous and active-low.
- sck  in  1  I2S serial clock; asynchronous to clk; frequency at most clk/4.
- ws  in  1  I2S word select; asynchronous.
- sd  in  1  I2S serial data; asynchronous.
- rx_en  in  1  receiver enable.
- word_size  in  2  00=16b, 01=24b, 10=32b, 11=reserved.
- frame_size  in  1  0=16-bit half-frame, 1=32-bit half-frame.
- standard  in  2  00=I2S (Philips), 01=MSB-justified, 10=LSB-justified, 11=reserved.
- stereo  in  1  1=deliver both channels; 0=deliver left only.
- mute  in  1  1=deliver zero data.
- rx_ready  in  1  consumer accepts rx_data.
- rx_data  out  32  received word, right-aligned, upper bits zero.
- rx_left  out  1  1=rx_data is the left channel.
- rx_valid  out  1  rx_data is valid.
- overrun  out  1  sticky: a word was lost.
- frame_err  out  1  sticky: the WS period violated the half-frame length.
- cfg_err  out  1  the configuration is illegal.
- state  out  2  IDLE=0, L=1, R=2, ERR=3.

Function
REQ-003 SHALL synchronize sck, ws and sd through SYNC_STAGES flops; an SCK rising edge is synchronized sck=1 while the previous registered sck=0.
REQ-004 SHALL sample ws and sd only on SCK rising edges.
REQ-005 SHALL define the left level as ws=0 for I2S and ws=1 for MSB- and LSB-justified.
REQ-006 SHALL latch word_size, frame_size, standard and stereo on leaving IDLE; later changes SHALL be ignored until the block returns to IDLE.
REQ-007 SHALL define W=16/24/32 from word_size and F=16/32 from frame_size.
- cfg_err=1 while rx_en=1 and any of: W>F, word_size=11, standard=11.
- While cfg_err=1 the state SHALL remain IDLE.
REQ-008 SHALL keep a bit position p, set to 0 at the SCK edge where a sampled ws differs from the previously sampled ws, and incremented on each later SCK edge.
REQ-009 SHALL shift sd into the word MSB-first at these positions, with completion as stated:
- I2S: p=1..W shifted. The slot ends on the edge with p=0 of the next WS change. The word completes at p=W.
- MSB-justified: p=0..W-1 shifted. The word completes at p=W-1.
- LSB-justified: p=F-W..F-1 shifted. The word completes at p=F-1.
- Bits outside the window SHALL be ignored.
REQ-010 SHALL implement the state machine as follows:
- IDLE -> L on the first ws change to the left level while rx_en=1 and cfg_err=0.
- L -> R on a ws change to the right level at p=F-1.
- R -> L on a ws change to the left level at p=F-1.
- L or R -> ERR on a ws change at p!=F-1, or when p reaches F without a ws change.
- ERR -> L on the next ws change to the left level; the partial word SHALL be discarded.
- Any state -> IDLE when rx_en=0.
REQ-011 SHALL load rx_data, rx_left and set rx_valid=1 on the same clk edge as the completing shift, which is SYNC_STAGES+1 clk edges after the raw sck rise.
REQ-012 SHALL load rx_data with zeros when mute=1; rx_valid SHALL still assert.
REQ-013 SHALL discard right-channel words when the latched stereo=0.
REQ-014 SHALL hold rx_valid, rx_data and rx_left until a clk cycle with rx_valid=1 and rx_ready=1; rx_valid SHALL drop on the next edge unless a new word loads.
REQ-015 SHALL handle a word completing while rx_valid=1 as follows:
- If rx_ready=0: overwrite rx_data and set overrun=1.
- If rx_ready=1: load the new word, keep rx_valid=1, and leave overrun unchanged.
REQ-016 SHALL set frame_err=1 on entry to ERR.
REQ-017 SHALL clear overrun and frame_err only on rst_n=0 or rx_en=0.
REQ-018 SHALL never deliver a word whose shift did not complete, in any of these cases: ERR entry, rx_en drop, reset.

Reset
REQ-019 SHALL, while rst_n=0, drive these values:
- all outputs 0.
- state=IDLE.
- p=0, the shift register and the synchronizers 0.
REQ-020 SHALL accept reset assertion mid-word; after release it SHALL wait in IDLE for a left-level ws edge.

Verification
REQ-021 I2S, W=16, F=16, stereo=1, rx_ready=1; send L=0xA5C3, R=0x0F0F -> rx_data=0x0000A5C3 with rx_left=1, then 0x00000F0F with rx_left=0, each as one rx_valid cycle.
REQ-022 LSB-justified, W=24, F=32; L slot = 8 ones followed by 0x123456 -> rx_data=0x00123456, rx_left=1.
REQ-023 rx_ready=0 across L=0x1111 then R=0x2222 -> overrun=1, rx_data=0x00002222, rx_valid held at 1.
REQ-024 F=16; ws toggles after 12 SCKs -> state=ERR, frame_err=1, no rx_valid. Then a full frame L=0xBEEF -> state=L, rx_data=0x0000BEEF.
REQ-025 word_size=10 with frame_size=0 and rx_en=1 -> cfg_err=1, state=IDLE, no rx_valid during 4 full frames.
REQ-026 rst_n pulsed low after 8 of 16 bits -> all outputs 0 and state=IDLE; the partial word is never delivered.
